// File: rtl/store_rmw_ctrl.sv
// Load/store sequencer for a single-port sync-read memory; sb stores run read-modify-write.
// Latency: sw 2, lw 2+RD_LAT, sb 3+RD_LAT cycles to resp_valid; req_ready only in IDLE (one op in flight).
module store_rmw_ctrl #(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_sb,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    RWAIT = 3'd2,
    WR    = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic              we_q;
  logic              sb_q;
  logic [1:0]        lane_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       merged;
  logic              accept;
  logic              capture;

  assign accept  = req_valid && req_ready;
  assign capture = (state == RWAIT) && (cnt_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      sb_q    <= 1'b0;
      lane_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      cnt_q   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q    <= req_we;
        sb_q    <= req_sb;
        lane_q  <= req_addr[1:0];
        addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
        wdata_q <= req_wdata;
      end
      // RD always hands over to RWAIT, so loading here is loading on RWAIT entry
      if (state == RD) begin
        cnt_q <= CNT_W'(RD_LAT - 1);
      end else if ((state == RWAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (capture) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  always_comb begin
    merged = rdata_q;
    case (lane_q)
      2'd0:    merged[7:0]   = wdata_q[7:0];
      2'd1:    merged[15:8]  = wdata_q[7:0];
      2'd2:    merged[23:16] = wdata_q[7:0];
      default: merged[31:24] = wdata_q[7:0];
    endcase
  end

  always_comb begin
    state_nxt  = state;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 32'h0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (req_we && !req_sb) ? WR : RD;
        end
      end
      RD: begin
        mem_en    = 1'b1;
        mem_addr  = addr_q;
        state_nxt = RWAIT;
      end
      RWAIT: begin
        mem_addr = addr_q;
        if (capture) begin
          state_nxt = we_q ? WR : RESP;
        end
      end
      WR: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = sb_q ? merged : wdata_q;
        state_nxt = RESP;
      end
      RESP: begin
        mem_addr   = addr_q;
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state is already IDLE while reset is high, so only req_ready needs the extra gate
  assign req_ready  = (state == IDLE) && !reset;
  assign busy       = (state != IDLE);
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Bench for store_rmw_ctrl: two instances (RD_LAT 1 and 3) share one memory model;
// a forked monitor pops expected responses queued at accept time and checks memory cycles.
module tb_store_rmw_ctrl;

  typedef struct {
    logic [31:0] addr;
    int          rd_cyc;
    int          wr_cyc;
    logic [31:0] wdata;
    int          resp_cyc;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        sel;
  logic        req_valid;
  logic        req_we;
  logic        req_sb;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rdy1, rsp1, en1, we1, bsy1;
  logic [31:0] rdat1, a1, wd1;
  logic        rdy3, rsp3, en3, we3, bsy3;
  logic [31:0] rdat3, a3, wd3;
  logic [31:0] rd1, p0, p1, p2;

  logic        rdy, rsp_vld, m_en, m_we, bsy;
  logic [31:0] rsp_dat, m_addr, m_wdata;

  logic [31:0] mem [0:255];
  bit          mem_init;

  exp_t        q[$];
  exp_t        pend;
  exp_t        e;
  int          n_checks;
  int          n_fail;
  int          n_resp;
  int          acc_cyc;
  int          last_gap;

  store_rmw_ctrl #(.RD_LAT(1), .ADDR_W(32)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid && !sel), .req_ready(rdy1),
    .req_we(req_we), .req_sb(req_sb), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rsp1), .resp_rdata(rdat1),
    .mem_en(en1), .mem_we(we1), .mem_addr(a1), .mem_wdata(wd1), .mem_rdata(rd1),
    .busy(bsy1)
  );

  store_rmw_ctrl #(.RD_LAT(3), .ADDR_W(32)) dut3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid && sel), .req_ready(rdy3),
    .req_we(req_we), .req_sb(req_sb), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rsp3), .resp_rdata(rdat3),
    .mem_en(en3), .mem_we(we3), .mem_addr(a3), .mem_wdata(wd3), .mem_rdata(p2),
    .busy(bsy3)
  );

  assign rdy     = sel ? rdy3  : rdy1;
  assign rsp_vld = sel ? rsp3  : rsp1;
  assign rsp_dat = sel ? rdat3 : rdat1;
  assign m_en    = sel ? en3   : en1;
  assign m_we    = sel ? we3   : we1;
  assign m_addr  = sel ? a3    : a1;
  assign m_wdata = sel ? wd3   : wd1;
  assign bsy     = sel ? bsy3  : bsy1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous memory: 1-cycle read path for dut1, 3-stage read pipe for dut3
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h80] <= 32'h11223344;
      mem[8'h81] <= 32'h11223344;
      mem[8'h82] <= 32'h11223344;
      mem[8'h83] <= 32'h11223344;
      mem[8'h84] <= 32'h11223344;
      mem[8'h10] <= 32'hCAFEF00D;
      mem_init   <= 1'b1;
    end else if (m_en && m_we) begin
      mem[m_addr[9:2]] <= m_wdata;
    end
    if (en1 && !we1) rd1 <= mem[a1[9:2]];
    p0 <= mem[a3[9:2]];
    p1 <= p0;
    p2 <= p1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] a, input int rd, input int wr,
                              input logic [31:0] wd, input int rs, input logic [31:0] rdat);
    exp_t r;
    r.addr = a; r.rd_cyc = rd; r.wr_cyc = wr; r.wdata = wd; r.resp_cyc = rs; r.rdata = rdat;
    return r;
  endfunction

  task automatic send(input logic we, input logic sb, input logic [31:0] addr,
                      input logic [31:0] wdata, input exp_t ex, input bit hold);
    int n;
    pend      = ex;
    req_we    = we;
    req_sb    = sb;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!rdy && n < 200);
    if (n >= 200) check("accept_timeout", 32'd0, 32'd1);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0 && !bsy) done = 1'b1;
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_sb = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; pend = mk(0, 0, 0, 0, 0, 0);

    fork
      forever begin
        @(posedge clk or negedge clk or posedge reset);
        if (reset) begin
          q.delete();
          acc_cyc = 0;
        end else if (clk) begin
          if (req_valid && rdy) begin
            last_gap = acc_cyc;
            q.push_back(pend);
            acc_cyc = 1;
          end else begin
            acc_cyc++;
          end
        end else begin
          if (m_en) begin
            if (q.size() == 0) begin
              check("spurious_mem_access", 32'd1, 32'd0);
            end else begin
              e = q[0];
              check("mem_addr", m_addr, e.addr);
              if (m_we) begin
                check("wr_cycle", 32'(acc_cyc), 32'(e.wr_cyc));
                check("mem_wdata", m_wdata, e.wdata);
              end else begin
                check("rd_cycle", 32'(acc_cyc), 32'(e.rd_cyc));
              end
            end
          end
          check("busy", 32'(bsy), 32'(q.size() != 0));
          check("req_ready", 32'(rdy), 32'(!bsy));
          if (!bsy) begin
            check("idle_mem_addr", m_addr, 32'h0);
            check("idle_mem_wdata", m_wdata, 32'h0);
          end
          if (rsp_vld) begin
            if (q.size() == 0) begin
              check("spurious_resp", 32'd1, 32'd0);
            end else begin
              e = q.pop_front();
              check("resp_cycle", 32'(acc_cyc), 32'(e.resp_cyc));
              check("resp_rdata", rsp_dat, e.rdata);
              n_resp++;
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready1", 32'(rdy1), 32'd0);
    check("rst_req_ready3", 32'(rdy3), 32'd0);
    check("rst_busy", 32'({bsy1, bsy3}), 32'd0);
    check("rst_mem_en", 32'({en1, en3, we1, we3}), 32'd0);
    check("rst_resp", 32'({rsp1, rsp3}), 32'd0);
    check("rst_rdata", rdat1 | rdat3, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(rdy), 32'd1);

    // RD_LAT = 1 instance
    send(1'b1, 1'b0, 32'h104, 32'hDEADBEEF, mk(32'h104, 0, 1, 32'hDEADBEEF, 2, 32'h0), 1'b0);
    wait_idle();
    send(1'b1, 1'b1, 32'h202, 32'h000000AB, mk(32'h200, 1, 3, 32'h11AB3344, 4, 32'h11223344), 1'b0);
    wait_idle();
    send(1'b1, 1'b1, 32'h204, 32'h123456AB, mk(32'h204, 1, 3, 32'h112233AB, 4, 32'h11223344), 1'b0);
    wait_idle();
    send(1'b1, 1'b1, 32'h209, 32'h000000AB, mk(32'h208, 1, 3, 32'h1122AB44, 4, 32'h11223344), 1'b0);
    wait_idle();
    // req_valid held high across a byte store, then a load of the written word
    send(1'b1, 1'b1, 32'h20F, 32'h000000AB, mk(32'h20C, 1, 3, 32'hAB223344, 4, 32'h11223344), 1'b1);
    send(1'b0, 1'b0, 32'h20C, 32'h0, mk(32'h20C, 1, 0, 32'h0, 3, 32'hAB223344), 1'b0);
    check("b2b_accept_gap", 32'(last_gap), 32'd5);
    wait_idle();
    send(1'b0, 1'b1, 32'h200, 32'hFFFFFFFF, mk(32'h200, 1, 0, 32'h0, 3, 32'h11AB3344), 1'b0);
    wait_idle();

    // RD_LAT = 3 instance
    sel = 1'b1;
    send(1'b0, 1'b0, 32'h43, 32'h0, mk(32'h40, 1, 0, 32'h0, 5, 32'hCAFEF00D), 1'b0);
    wait_idle();
    send(1'b1, 1'b0, 32'h105, 32'h12345678, mk(32'h104, 0, 1, 32'h12345678, 2, 32'hCAFEF00D), 1'b0);
    wait_idle();
    send(1'b0, 1'b0, 32'h104, 32'h0, mk(32'h104, 1, 0, 32'h0, 5, 32'h12345678), 1'b0);
    wait_idle();

    // reset in the WR cycle of a byte store aborts it
    sel = 1'b0;
    send(1'b1, 1'b1, 32'h211, 32'h00000055, mk(32'h210, 1, 3, 32'h11225544, 4, 32'h11223344), 1'b0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (m_we) seen = 1'b1;
      end
      check("abort_saw_wr", 32'(seen), 32'd1);
    end
    #2;
    reset = 1'b1;
    #1;
    check("abort_mem_en", 32'({m_en, m_we}), 32'd0);
    check("abort_busy", 32'(bsy), 32'd0);
    check("abort_resp", 32'(rsp_vld), 32'd0);
    check("abort_ready", 32'(rdy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_hold_mem_en", 32'({m_en, m_we, bsy}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready_after", 32'(rdy), 32'd1);
    check("abort_rdata_clear", rdat1, 32'h0);
    repeat (6) @(posedge clk);
    #1;

    check("resp_count", 32'(n_resp), 32'd10);
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/store_rmw_ctrl.md
Name: store_rmw_ctrl

Overview:
- Multi-cycle memory access sequencer between the processor's load/store request and a single-port, synchronous-read data memory.
- Word stores are written directly.
- Byte stores (sb) run read-modify-write: read the aligned word, merge the source byte into the lane selected by addr[1:0], write the merged word back.
- Loads read the aligned word and return it whole; sign/zero extension happens downstream.

Parameters:
- RD_LAT, 1: memory read latency in cycles (>=1). mem_rdata is valid RD_LAT cycles after a read-issue cycle.
- ADDR_W, 32: byte address width. Data width is fixed at 32.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_sb  in  1  store type: 1 = byte store, 0 = word store; ignored for loads
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store source register value; byte stores use bits 7:0
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  last word captured from memory
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2], 2'b00}
- mem_wdata  out  32  write data
- mem_rdata  in  32  memory read data
- busy  out  1  high in every state except IDLE; used as pipeline stall

Behaviour:
- Reset (async, immediate):
  - State goes to IDLE; all registers clear.
  - All outputs read 0, including req_ready while reset is high.
  - A reset during RD, RWAIT or WR aborts the access: mem_en and mem_we drop at once, and no resp_valid is produced.
  - After reset deasserts, req_ready = 1.
- Accept: a handshake is req_valid & req_ready at a rising edge in IDLE. On accept, latch we, sb, addr, wdata, and lane = addr[1:0]. Request inputs are ignored in every other state.
- States: IDLE, RD, RWAIT, WR, RESP.
- Transitions:
  - IDLE -> WR on an accepted word store.
  - IDLE -> RD on an accepted load or byte store.
  - RD -> RWAIT after exactly 1 cycle.
  - RWAIT is held RD_LAT cycles via a down-counter loaded with RD_LAT-1 on entry. When the counter reaches 0, capture mem_rdata into the read register.
    - Load: RWAIT -> RESP.
    - Byte store: RWAIT -> WR.
  - WR -> RESP after 1 cycle.
  - RESP -> IDLE after 1 cycle.
- Outputs per state:
  - IDLE: mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - RD: mem_en = 1, mem_we = 0, mem_addr = latched aligned address.
  - RWAIT: mem_en = 0, mem_we = 0, mem_addr held.
  - WR: mem_en = 1, mem_we = 1, mem_addr held, mem_wdata as below.
  - RESP: resp_valid = 1, for exactly one cycle.
- Write data in WR:
  - Word store: latched wdata.
  - Byte store: captured read word with byte lane replaced by wdata[7:0].
    - lane 0 -> bits 7:0
    - lane 1 -> bits 15:8
    - lane 2 -> bits 23:16
    - lane 3 -> bits 31:24
    - All other bytes come unchanged from the read word.
- resp_rdata: updated only on read capture; holds its value otherwise (including through word stores); reset value 0.
- Latency, with the accept edge ending cycle 0:
  - Word store: WR in cycle 1, resp_valid in cycle 2.
  - Load: RD in cycle 1, RWAIT in cycles 2..1+RD_LAT, resp_valid in cycle 2+RD_LAT.
  - Byte store: same as load through RWAIT, WR in cycle 2+RD_LAT, resp_valid in cycle 3+RD_LAT.
- Back-to-back: req_ready returns high in the cycle after RESP, so the minimum spacing between accepts is the op latency + 1.
- Misaligned word addresses are not faulted; addr[1:0] is dropped on mem_addr.

Test Plan:
- Word store, addr 0x104, wdata 0xDEADBEEF -> cycle 1: mem_en=1, mem_we=1, mem_addr=0x104, mem_wdata=0xDEADBEEF; cycle 2: resp_valid=1; cycle 3: req_ready=1.
- Byte store, RD_LAT=1, memory word 0x11223344 at 0x200, addr 0x202, wdata 0x000000AB -> RD cycle 1 (mem_we=0); WR cycle 3 with mem_wdata=0x11AB3344; resp_valid cycle 4. Repeat for lanes 0, 1 and 3 -> 0x112233AB, 0x1122AB44, 0xAB223344.
- Load, RD_LAT=3, memory 0xCAFEF00D at 0x40, addr 0x43 -> mem_addr=0x40; busy for cycles 1..5; resp_valid in cycle 5 with resp_rdata=0xCAFEF00D.
- req_valid held high across a byte store -> no second accept until IDLE; the next accept lands on the edge ending the cycle after RESP; no requests lost or duplicated.
- Reset asserted mid-WR of a byte store -> mem_en, mem_we, busy and resp_valid go 0 asynchronously; no resp_valid is produced; after release, IDLE with req_ready=1.
- Word store following a load -> resp_rdata keeps the load value through the word store's RESP cycle.
